// File: rtl/slot_spin_ctrl.sv
// Slot machine sequencer: spins three reels from the random digit stream, stops them in turn,
// scores the result and keeps the credit balance. Optional stop button: SLOT_STOP_BTN_EN.
module slot_spin_ctrl #(
  parameter int unsigned SPIN_CYCLES = 100,
  parameter int unsigned GAP_CYCLES  = 50,
  parameter int unsigned CREDIT_INIT = 10,
  parameter int unsigned PAIR_PAY    = 2,
  parameter int unsigned JACKPOT_PAY = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spin,
`ifdef SLOT_STOP_BTN_EN
  input  logic       stop,
`endif
  input  logic [3:0] rnd,
  output logic [3:0] reel0,
  output logic [3:0] reel1,
  output logic [3:0] reel2,
  output logic       busy,
  output logic       done,
  output logic       win,
  output logic       jackpot,
  output logic [7:0] credits,
  output logic       broke
);

  localparam int unsigned CntMax = (SPIN_CYCLES > GAP_CYCLES) ? SPIN_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] SpinLast = CntW'(SPIN_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StSpin, StHold1, StHold2, StEval} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      reel0_q, reel0_d, reel1_q, reel1_d, reel2_q, reel2_d;
  logic            busy_q, busy_d, done_q, done_d, win_q, win_d, jackpot_q, jackpot_d;
  logic [7:0]      credits_q, credits_d;
  logic            spin_q;
  logic            spin_edge, stop_edge;
  logic            all_eq, any_eq;
  logic [7:0]      pay;
  logic [8:0]      sum;

  assign spin_edge = spin & ~spin_q;

`ifdef SLOT_STOP_BTN_EN
  logic stop_q;
  assign stop_edge = stop & ~stop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stop_q <= 1'b0;
    else          stop_q <= stop;
  end
`else
  assign stop_edge = 1'b0;
`endif

  assign all_eq = (reel0_q == reel1_q) && (reel1_q == reel2_q);
  assign any_eq = (reel0_q == reel1_q) || (reel1_q == reel2_q) || (reel0_q == reel2_q);
  assign pay    = all_eq ? 8'(JACKPOT_PAY) : (any_eq ? 8'(PAIR_PAY) : 8'd0);
  assign sum    = {1'b0, credits_q} + {1'b0, pay};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reel0_d   = reel0_q;
    reel1_d   = reel1_q;
    reel2_d   = reel2_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    win_d     = win_q;
    jackpot_d = jackpot_q;
    credits_d = credits_q;
    case (state_q)
      StIdle: begin
        if (spin_edge && (credits_q != 8'd0)) begin
          credits_d = credits_q - 8'd1;
          win_d     = 1'b0;
          jackpot_d = 1'b0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = StSpin;
        end
      end
      StSpin: begin
        reel0_d = rnd;
        reel1_d = reel0_q;
        reel2_d = reel1_q;
        if ((cnt_q == SpinLast) || stop_edge) begin
          cnt_d   = '0;
          state_d = StHold1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold1: begin
        reel1_d = reel0_q;
        reel2_d = reel1_q;
        if ((cnt_q == GapLast) || stop_edge) begin
          reel1_d = rnd;
          cnt_d   = '0;
          state_d = StHold2;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold2: begin
        reel2_d = reel1_q;
        if ((cnt_q == GapLast) || stop_edge) begin
          reel2_d = rnd;
          cnt_d   = '0;
          state_d = StEval;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StEval: begin
        win_d     = any_eq;
        jackpot_d = all_eq;
        // Payout saturates rather than wrapping the 8-bit balance
        credits_d = sum[8] ? 8'hFF : sum[7:0];
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      reel0_q   <= 4'd0;
      reel1_q   <= 4'd0;
      reel2_q   <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      win_q     <= 1'b0;
      jackpot_q <= 1'b0;
      credits_q <= 8'(CREDIT_INIT);
      spin_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reel0_q   <= reel0_d;
      reel1_q   <= reel1_d;
      reel2_q   <= reel2_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      win_q     <= win_d;
      jackpot_q <= jackpot_d;
      credits_q <= credits_d;
      spin_q    <= spin;
    end
  end

  assign reel0   = reel0_q;
  assign reel1   = reel1_q;
  assign reel2   = reel2_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign win     = win_q;
  assign jackpot = jackpot_q;
  assign credits = credits_q;
  assign broke   = (credits_q == 8'd0);

endmodule

// File: tb/tb_slot_spin_ctrl.sv
// Bench for slot_spin_ctrl with short spin/gap timing; stop-button sequence under SLOT_STOP_BTN_EN.
module tb_slot_spin_ctrl;

  localparam int S = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spin = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] rnd = 4'd0;
  logic [3:0] reel0, reel1, reel2;
  logic       busy, done, win, jackpot, broke;
  logic [7:0] credits;

  int total = 0;
  int bad = 0;
  int credits_m = 10;

  slot_spin_ctrl #(
    .SPIN_CYCLES(S),
    .GAP_CYCLES (G),
    .CREDIT_INIT(10),
    .PAIR_PAY   (2),
    .JACKPOT_PAY(20)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .spin   (spin),
`ifdef SLOT_STOP_BTN_EN
    .stop   (stop),
`endif
    .rnd    (rnd),
    .reel0  (reel0),
    .reel1  (reel1),
    .reel2  (reel2),
    .busy   (busy),
    .done   (done),
    .win    (win),
    .jackpot(jackpot),
    .credits(credits),
    .broke  (broke)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f0, f1, f2;
    bit         noisy;
    bit         exp_win;
    bit         exp_jack;
    int         exp_delta;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoring by number of distinct digits: 1 -> jackpot, 2 -> pair, 3 -> nothing
  task automatic judge(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       output bit w, output bit j, output int p);
    int hist[10];
    int distinct;
    foreach (hist[i]) hist[i] = 0;
    hist[a]++;
    hist[b]++;
    hist[c]++;
    distinct = 0;
    foreach (hist[i]) if (hist[i] != 0) distinct++;
    j = (distinct == 1);
    w = (distinct <= 2);
    p = j ? 20 : (w ? 2 : 0);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    spin = 1'b0;
    stop = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    credits_m = 10;
    tick();
  endtask

  // One full spin; finals f0..f2 are driven on the stop edges, random digits elsewhere.
  task automatic run_spin(input logic [3:0] f0, input logic [3:0] f1, input logic [3:0] f2,
                          input bit noisy, input bit hold,
                          input bit exp_win, input bit exp_jack, input int exp_cr);
    spin = 1'b0;
    tick();
    chk("pre_idle", busy, 0);
    spin = 1'b1;
    tick();
    credits_m--;
    chk("start_busy", busy, 1);
    chk("start_credits", credits, credits_m);
    chk("start_win_clr", win, 0);
    chk("start_jack_clr", jackpot, 0);
    if (!hold) spin = 1'b0;
    for (int k = 1; k <= S + 2 * G; k++) begin
      if (k == S) rnd = f0;
      else if (k == S + G) rnd = f1;
      else if (k == S + 2 * G) rnd = f2;
      else rnd = 4'($urandom_range(0, 9));
      if (noisy && !hold) spin = 1'($urandom_range(0, 1));
      tick();
      chk("spin_done_low", done, 0);
      if (k == S) chk("reel0_final", reel0, f0);
      if (k == S + G) begin
        chk("reel0_held", reel0, f0);
        chk("reel1_final", reel1, f1);
      end
      if (k == S + 2 * G) begin
        chk("reel1_held", reel1, f1);
        chk("reel2_final", reel2, f2);
        chk("busy_before_eval", busy, 1);
      end
    end
    rnd = 4'($urandom_range(0, 9));
    tick();
    credits_m = exp_cr;
    chk("eval_done", done, 1);
    chk("eval_busy", busy, 0);
    chk("eval_win", win, exp_win);
    chk("eval_jackpot", jackpot, exp_jack);
    chk("eval_credits", credits, credits_m);
    chk("eval_broke", broke, credits_m == 0);
    tick();
    chk("done_pulse_end", done, 0);
    chk("idle_reel0", reel0, f0);
    chk("idle_reel2", reel2, f2);
    if (hold) begin
      tick();
      tick();
      chk("held_no_respin", busy, 0);
      chk("held_credits", credits, credits_m);
      spin = 1'b0;
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit w, j;
    int p, cr;
    logic [3:0] a, b, c;
    int done_cnt;

    vecs[0] = '{f0: 7, f1: 7, f2: 7, noisy: 0, exp_win: 1, exp_jack: 1, exp_delta: 19};
    vecs[1] = '{f0: 3, f1: 3, f2: 5, noisy: 0, exp_win: 1, exp_jack: 0, exp_delta: 1};
    vecs[2] = '{f0: 1, f1: 2, f2: 3, noisy: 1, exp_win: 0, exp_jack: 0, exp_delta: -1};
    vecs[3] = '{f0: 4, f1: 9, f2: 4, noisy: 1, exp_win: 1, exp_jack: 0, exp_delta: 1};
    vecs[4] = '{f0: 0, f1: 0, f2: 0, noisy: 1, exp_win: 1, exp_jack: 1, exp_delta: 19};
    vecs[5] = '{f0: 9, f1: 8, f2: 8, noisy: 0, exp_win: 1, exp_jack: 0, exp_delta: 1};

    do_reset();
    chk("rst_credits", credits, 10);
    chk("rst_reel0", reel0, 0);
    chk("rst_reel1", reel1, 0);
    chk("rst_reel2", reel2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_broke", broke, 0);
    chk("rst_win", win, 0);
    chk("rst_jackpot", jackpot, 0);
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      rnd = 4'($urandom_range(0, 9));
      tick();
      if (done) done_cnt++;
    end
    chk("rst_no_done", done_cnt, 0);

    foreach (vecs[i])
      run_spin(vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].noisy, 1'b0,
               vecs[i].exp_win, vecs[i].exp_jack, credits_m + vecs[i].exp_delta);

    // Button held through done must not restart
    run_spin(4'd5, 4'd6, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, credits_m - 1);

    for (int i = 0; i < 20; i++) begin
      if (credits_m == 0) break;
      a = 4'($urandom_range(0, 3));
      b = 4'($urandom_range(0, 3));
      c = 4'($urandom_range(0, 3));
      judge(a, b, c, w, j, p);
      cr = credits_m - 1 + p;
      if (cr > 255) cr = 255;
      run_spin(a, b, c, 1'(i % 2), 1'b0, w, j, cr);
    end

    // Asynchronous reset while in HOLD1
    spin = 1'b0;
    tick();
    spin = 1'b1;
    tick();
    spin = 1'b0;
    for (int k = 1; k <= S + 1; k++) begin
      rnd = 4'($urandom_range(1, 9));
      tick();
    end
    chk("hold1_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_credits", credits, 10);
    chk("arst_busy", busy, 0);
    chk("arst_reel0", reel0, 0);
    chk("arst_done", done, 0);
    chk("arst_win", win, 0);
    @(negedge clk);
    reset_n = 1'b1;
    credits_m = 10;
    tick();
    run_spin(4'd2, 4'd2, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 29);

    // Ten losing spins drain the balance, then spin is refused
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a = 4'($urandom_range(0, 9));
      run_spin(a, 4'((a + 1) % 10), 4'((a + 2) % 10), 1'b1, 1'b0, 1'b0, 1'b0, credits_m - 1);
    end
    chk("broke_credits", credits, 0);
    chk("broke_flag", broke, 1);
    spin = 1'b0;
    tick();
    spin = 1'b1;
    tick();
    chk("broke_no_start", busy, 0);
    chk("broke_credits_hold", credits, 0);
    spin = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) done_cnt++;
    end
    chk("broke_stays_idle", done_cnt, 0);

    // Saturation at 255 under repeated jackpots
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cr = credits_m - 1 + 20;
      if (cr > 255) cr = 255;
      run_spin(4'd8, 4'd8, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, cr);
    end
    chk("sat_credits", credits, 255);

`ifdef SLOT_STOP_BTN_EN
    do_reset();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    chk("stop_idle_ignored", busy, 0);
    spin = 1'b1;
    tick();
    spin = 1'b0;
    rnd = 4'd1;
    tick();
    stop = 1'b1;
    rnd = 4'd6;
    tick();
    chk("stop_reel0", reel0, 6);
    chk("stop_busy", busy, 1);
    stop = 1'b0;
    rnd = 4'd3;
    tick();
    chk("stop_reel0_held", reel0, 6);
    stop = 1'b1;
    rnd = 4'd6;
    tick();
    chk("stop_coincide_reel1", reel1, 6);
    stop = 1'b0;
    rnd = 4'd9;
    tick();
    chk("stop_one_reel_busy", busy, 1);
    chk("stop_one_reel_done", done, 0);
    rnd = 4'd2;
    tick();
    chk("stop_reel2_timed", reel2, 2);
    chk("stop_reel2_busy", busy, 1);
    rnd = 4'd0;
    tick();
    chk("stop_done", done, 1);
    chk("stop_win", win, 1);
    chk("stop_jackpot", jackpot, 0);
    chk("stop_credits", credits, 11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
